vx_dp_ram_ctrl: RTL and testbench

//  Front-end controller for the dual-port RAM primitive: turns a valid/ready write stream and a valid/ready

---
 rtl/vx_dp_ram_ctrl_pkg.sv | 19 +
 rtl/vx_dp_ram_ctrl_if.sv | 42 ++++
 rtl/VX_fifo_queue.sv | 74 +++++++
 rtl/vx_dp_ram_ctrl.sv | 155 +++++++++++++++
 tb/tb_vx_dp_ram_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_dp_ram_ctrl_pkg.sv
// Shared types and sizing helpers for the dual-port RAM front-end controller.
package vx_dp_ram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Address width for n entries; never narrower than one bit.
  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned credit_w(input int unsigned depth);
    return log2up(depth + 1);
  endfunction

endpackage

// File: rtl/vx_dp_ram_ctrl_if.sv
// Client-side streams of the RAM controller: write, read request, read response.
interface vx_dp_ram_ctrl_if #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned ADDRW = 6,
  parameter int unsigned WRENW = 1
);

  logic             wr_valid;
  logic             wr_ready;
  logic [ADDRW-1:0] wr_addr;
  logic [WRENW-1:0] wr_wren;
  logic [DATAW-1:0] wr_data;

  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [ADDRW-1:0] rd_req_addr;

  logic             rd_rsp_valid;
  logic             rd_rsp_ready;
  logic [DATAW-1:0] rd_rsp_data;

  // Client side: issues writes and read requests, consumes responses.
  modport master (
    output wr_valid, wr_addr, wr_wren, wr_data,
    input  wr_ready,
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready,
    input  rd_rsp_valid, rd_rsp_data,
    output rd_rsp_ready
  );

  // Controller side.
  modport slave (
    input  wr_valid, wr_addr, wr_wren, wr_data,
    output wr_ready,
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready,
    output rd_rsp_valid, rd_rsp_data,
    input  rd_rsp_ready
  );

endinterface

// File: rtl/VX_fifo_queue.sv
// Circular FIFO used as the read-response buffer; data_out is stable until popped.
module VX_fifo_queue #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNTW'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem_q[rd_ptr_q];

  // Pointer and occupancy update.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state; reset empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written on push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: rtl/vx_dp_ram_ctrl.sv
// Dual-port RAM front-end: init sweep, zero-latency write path, credit-bounded
// read issue and an in-order, backpressurable read response stream.
module vx_dp_ram_ctrl
  import vx_dp_ram_ctrl_pkg::*;
#(
  parameter int unsigned      DATAW      = 32,
  parameter int unsigned      SIZE       = 64,
  parameter int unsigned      WRENW      = 1,
  parameter int unsigned      OUT_REG    = 1,
  parameter int unsigned      RSP_DEPTH  = 2,
  parameter logic [DATAW-1:0] INIT_VALUE = '0,
  parameter int unsigned      ADDRW      = log2up(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  vx_dp_ram_ctrl_if.slave  bus,
  output logic             ram_write,
  output logic [WRENW-1:0] ram_wren,
  output logic [ADDRW-1:0] ram_waddr,
  output logic [DATAW-1:0] ram_wdata,
  output logic             ram_read,
  output logic [ADDRW-1:0] ram_raddr,
  input  logic [DATAW-1:0] ram_rdata,
  output logic             init_busy
);

  localparam int unsigned CRDW = credit_w(RSP_DEPTH);

  state_e           state_q, state_d;
  logic [ADDRW-1:0] init_addr_q, init_addr_d;
  logic [CRDW-1:0]  credit_q, credit_d;
  logic             run;
  logic             wr_fire;
  logic             rd_fire;
  logic             rsp_push;
  logic             rsp_pop;
  logic             buf_empty;

  assign run       = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);

  assign bus.wr_ready     = run;
  assign wr_fire          = run & bus.wr_valid;
  assign rsp_pop          = bus.rd_rsp_ready & ~buf_empty;
  // A response popped this cycle returns its credit immediately.
  assign bus.rd_req_ready = run & ((credit_q < CRDW'(RSP_DEPTH)) | rsp_pop);
  assign rd_fire          = bus.rd_req_valid & bus.rd_req_ready;
  assign bus.rd_rsp_valid = ~buf_empty;

  // Init sweep sequencing: one entry per cycle, then hand over to RUN.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == ADDRW'(SIZE - 1)) begin
        state_d     = ST_RUN;
        init_addr_d = '0;
      end
    end
  end

  // FSM and init address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // RAM port strobes; the INIT write is qualified by reset so nothing is
  // written while reset is held even though the state already reads INIT.
  always_comb begin
    ram_write = 1'b0;
    ram_wren  = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_read  = 1'b0;
    ram_raddr = '0;
    if (init_busy && reset) begin
      ram_write = 1'b1;
      ram_wren  = '1;
      ram_waddr = init_addr_q;
      ram_wdata = INIT_VALUE;
    end else if (wr_fire) begin
      ram_write = |bus.wr_wren;
      ram_wren  = bus.wr_wren;
      ram_waddr = bus.wr_addr;
      ram_wdata = bus.wr_data;
    end
    if (rd_fire) begin
      ram_read  = 1'b1;
      ram_raddr = bus.rd_req_addr;
    end
  end

  // Credits cover reads in flight plus entries held in the response buffer.
  always_comb begin
    credit_d = credit_q;
    if (rd_fire && !rsp_pop) begin
      credit_d = credit_q + 1'b1;
    end else if (!rd_fire && rsp_pop) begin
      credit_d = credit_q - 1'b1;
    end
  end

  // Credit counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  if (OUT_REG == 0) begin : g_no_pipe
    assign rsp_push = rd_fire;
  end else begin : g_pipe
    logic [OUT_REG-1:0] pipe_q, pipe_d;

    // Shift issued-read markers until their data is on ram_rdata.
    always_comb begin
      pipe_d    = pipe_q << 1;
      pipe_d[0] = rd_fire;
    end

    // Read-valid pipe register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign rsp_push = pipe_q[OUT_REG-1];
  end

  VX_fifo_queue #(
    .DATAW (DATAW),
    .DEPTH (RSP_DEPTH)
  ) rsp_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (rsp_push),
    .pop      (rsp_pop),
    .data_in  (ram_rdata),
    .data_out (bus.rd_rsp_data),
    .empty    (buf_empty)
  );

endmodule

// File: tb/tb_vx_dp_ram_ctrl.sv
// Scoreboard bench for vx_dp_ram_ctrl with a behavioural RAM and reference memory.
module tb_vx_dp_ram_ctrl;

  localparam int unsigned DATAW     = 32;
  localparam int unsigned SIZE      = 64;
  localparam int unsigned WRENW     = 4;
  localparam int unsigned OUT_REG   = 1;
  localparam int unsigned RSP_DEPTH = 2;
  localparam int unsigned ADDRW     = 6;
  localparam int unsigned LANEW     = DATAW / WRENW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vx_dp_ram_ctrl_if #(.DATAW(DATAW), .ADDRW(ADDRW), .WRENW(WRENW)) bus ();

  logic             ram_write, ram_read, init_busy;
  logic [WRENW-1:0] ram_wren;
  logic [ADDRW-1:0] ram_waddr, ram_raddr;
  logic [DATAW-1:0] ram_wdata, ram_rdata;

  vx_dp_ram_ctrl #(
    .DATAW      (DATAW),
    .SIZE       (SIZE),
    .WRENW      (WRENW),
    .OUT_REG    (OUT_REG),
    .RSP_DEPTH  (RSP_DEPTH),
    .INIT_VALUE (32'h0),
    .ADDRW      (ADDRW)
  ) dut (
    .clk       (clk),
    .reset     (reset_n),
    .bus       (bus),
    .ram_write (ram_write),
    .ram_wren  (ram_wren),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_read  (ram_read),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .init_busy (init_busy)
  );

  function automatic logic [DATAW-1:0] merge(input logic [DATAW-1:0] old_w,
                                             input logic [DATAW-1:0] new_w,
                                             input logic [WRENW-1:0] we);
    logic [DATAW-1:0] r;
    r = old_w;
    for (int l = 0; l < int'(WRENW); l++)
      if (we[l]) r[l*LANEW +: LANEW] = new_w[l*LANEW +: LANEW];
    return r;
  endfunction

  // RAM primitive: synchronous lane write, registered read gated by ram_read.
  logic [DATAW-1:0] ram_mem [SIZE];
  logic [DATAW-1:0] ram_rd_q = '0;
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_waddr] <= merge(ram_mem[ram_waddr], ram_wdata, ram_wren);
    if (ram_read) ram_rd_q <= ram_mem[ram_raddr];
  end
  assign ram_rdata = ram_rd_q;

  // Reference model state.
  logic [DATAW-1:0] ref_mem [SIZE];
  logic [DATAW-1:0] exp_q [$];
  int n_issued = 0;
  int n_popped = 0;
  logic running = 1'b0;
  int checks = 0;
  int failures = 0;
  int rsp_mode = 0;  // 0: always ready, 1: never ready, 2: random
  logic last_rsp_valid;
  logic wacc_o, racc_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: drives rd_rsp_ready, pops the scoreboard on each handshake.
  logic hold_pend = 1'b0;
  logic [DATAW-1:0] hold_data;
  initial begin
    bus.rd_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rsp_mode)
        0:       bus.rd_rsp_ready = 1'b1;
        1:       bus.rd_rsp_ready = 1'b0;
        default: bus.rd_rsp_ready = ($urandom_range(0, 99) < 70);
      endcase
      #1;
      if (!reset_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("rsp_hold_valid", bus.rd_rsp_valid, 1);
          chk("rsp_hold_data", bus.rd_rsp_data, hold_data);
        end
        hold_pend = 1'b0;
        if (bus.rd_rsp_valid) begin
          if (bus.rd_rsp_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL rsp_unexpected: got %0h expected no response", bus.rd_rsp_data);
            end else begin
              chk("rsp_data", bus.rd_rsp_data, exp_q.pop_front());
            end
            n_popped++;
          end else begin
            hold_pend = 1'b1;
            hold_data = bus.rd_rsp_data;
          end
        end
      end
    end
  end

  // One client cycle: drive at negedge, check strobes/readies, update the model.
  task automatic cycle(input logic wv, input logic [ADDRW-1:0] wa, input logic [WRENW-1:0] we,
                       input logic [DATAW-1:0] wd, input logic rv, input logic [ADDRW-1:0] ra,
                       output logic wacc, output logic racc);
    logic wm, rm;
    @(negedge clk);
    bus.wr_valid     = wv;
    bus.wr_addr      = wa;
    bus.wr_wren      = we;
    bus.wr_data      = wd;
    bus.rd_req_valid = rv;
    bus.rd_req_addr  = ra;
    #2;
    last_rsp_valid = bus.rd_rsp_valid;
    wm   = wv && running;
    rm   = rv && running && ((n_issued - n_popped) < int'(RSP_DEPTH));
    wacc = wv && bus.wr_ready;
    racc = rv && bus.rd_req_ready;
    chk("wr_ready", bus.wr_ready, running);
    chk("rd_req_ready", bus.rd_req_ready,
        running && ((n_issued - n_popped) < int'(RSP_DEPTH)));
    chk("ram_write", ram_write, wm && (we != '0));
    if (wm && (we != '0)) begin
      chk("ram_waddr", ram_waddr, wa);
      chk("ram_wdata", ram_wdata, wd);
      chk("ram_wren", ram_wren, we);
    end
    chk("ram_read", ram_read, rm);
    if (rm) begin
      chk("ram_raddr", ram_raddr, ra);
      exp_q.push_back(ref_mem[ra]);
      n_issued++;
    end
    if (wm) ref_mem[wa] = merge(ref_mem[wa], wd, we);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, '0, wacc_o, racc_o);
  endtask

  // Hold reset, release it, then follow the whole init sweep.
  task automatic reset_and_init();
    reset_n = 1'b0;
    running = 1'b0;
    exp_q.delete();
    n_issued = 0;
    n_popped = 0;
    bus.wr_valid     = 1'b1;
    bus.wr_wren      = '1;
    bus.wr_addr      = 6'd9;
    bus.wr_data      = 32'hDEAD_BEEF;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = 6'd9;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_init_busy", init_busy, 1);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_req_ready", bus.rd_req_ready, 0);
    chk("rst_rsp_valid", bus.rd_rsp_valid, 0);
    chk("rst_ram_waddr", ram_waddr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < int'(SIZE); i++) begin
      #1;
      chk("init_busy", init_busy, 1);
      chk("init_ram_write", ram_write, 1);
      chk("init_ram_waddr", ram_waddr, i);
      chk("init_ram_wdata", ram_wdata, 0);
      chk("init_ram_wren", ram_wren, 4'hF);
      chk("init_wr_ready", bus.wr_ready, 0);
      chk("init_rd_req_ready", bus.rd_req_ready, 0);
      chk("init_ram_read", ram_read, 0);
      @(negedge clk);
    end
    bus.wr_valid     = 1'b0;
    bus.rd_req_valid = 1'b0;
    #1;
    chk("init_done", init_busy, 0);
    for (int i = 0; i < int'(SIZE); i++) ref_mem[i] = '0;
    running = 1'b1;
  endtask

  initial begin
    int acc;
    bus.wr_valid     = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_wren      = '0;
    bus.wr_data      = '0;
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = '0;

    reset_and_init();

    // Basic write then read with latency check.
    cycle(1'b1, 6'd5, 4'hF, 32'hA5A5_A5A5, 1'b0, '0, wacc_o, racc_o);
    cycle(1'b0, '0, '0, '0, 1'b1, 6'd5, wacc_o, racc_o);
    chk("rd5_accept", racc_o, 1);
    idle(1);
    chk("lat_cycle1_valid", last_rsp_valid, 0);
    idle(1);
    chk("lat_cycle2_valid", last_rsp_valid, 1);
    idle(2);

    // Same-cycle write and read of one address returns old data.
    cycle(1'b1, 6'd7, 4'hF, 32'h0000_1234, 1'b1, 6'd7, wacc_o, racc_o);
    cycle(1'b0, '0, '0, '0, 1'b1, 6'd7, wacc_o, racc_o);
    idle(4);

    // Backpressure: credits stop read issue at RSP_DEPTH.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 6'(10 + i), 4'hF, 32'hC0DE_0000 + i, 1'b0, '0, wacc_o, racc_o);
    rsp_mode = 1;
    idle(1);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, '0, '0, 1'b1, 6'(10 + i), wacc_o, racc_o);
      if (racc_o) acc++;
    end
    chk("bp_accepts", acc, 2);
    idle(3);
    chk("bp_rsp_valid", last_rsp_valid, 1);
    rsp_mode = 0;
    idle(5);
    chk("bp_drained", exp_q.size(), 0);

    // Lane enables and a write with no lanes enabled.
    cycle(1'b1, 6'd3, 4'b0010, 32'hFFFF_FFFF, 1'b0, '0, wacc_o, racc_o);
    cycle(1'b0, '0, '0, '0, 1'b1, 6'd3, wacc_o, racc_o);
    cycle(1'b1, 6'd3, 4'b0000, 32'h1111_1111, 1'b0, '0, wacc_o, racc_o);
    chk("wren0_accepted", wacc_o, 1);
    cycle(1'b0, '0, '0, '0, 1'b1, 6'd3, wacc_o, racc_o);
    idle(4);

    // Reset while responses are buffered.
    rsp_mode = 1;
    idle(1);
    cycle(1'b0, '0, '0, '0, 1'b1, 6'd5, wacc_o, racc_o);
    cycle(1'b0, '0, '0, '0, 1'b1, 6'd7, wacc_o, racc_o);
    idle(3);
    chk("pre_rst_rsp_valid", last_rsp_valid, 1);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rd_rsp_valid, 0);
    chk("midrst_init_busy", init_busy, 1);
    rsp_mode = 0;
    reset_and_init();
    cycle(1'b0, '0, '0, '0, 1'b1, 6'd5, wacc_o, racc_o);
    idle(4);

    // Randomised traffic with random response backpressure.
    rsp_mode = 2;
    for (int n = 0; n < 1500; n++) begin
      logic [WRENW-1:0] we;
      case ($urandom_range(0, 3))
        0, 1:    we = '1;
        2:       we = WRENW'($urandom);
        default: we = '0;
      endcase
      cycle(1'($urandom), 6'($urandom_range(0, 15)), we, $urandom,
            1'($urandom), 6'($urandom_range(0, 15)), wacc_o, racc_o);
    end

    // Drain with a bounded wait.
    rsp_mode = 0;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) idle(1);
    chk("final_drain", exp_q.size(), 0);
    idle(2);
    chk("final_rsp_valid", last_rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
